// File: rtl/ls_queue_unit_pkg.sv
// Shared constants for the load/store queue: opcodes, access lengths, direction,
// extension mode and the issue FSM encoding.
package ls_queue_unit_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_LB  = 6'd0;
    localparam logic [OPC_W-1:0] OP_LH  = 6'd1;
    localparam logic [OPC_W-1:0] OP_LW  = 6'd2;
    localparam logic [OPC_W-1:0] OP_LBU = 6'd3;
    localparam logic [OPC_W-1:0] OP_LHU = 6'd4;
    localparam logic [OPC_W-1:0] OP_SB  = 6'd5;
    localparam logic [OPC_W-1:0] OP_SH  = 6'd6;
    localparam logic [OPC_W-1:0] OP_SW  = 6'd7;

    localparam logic [2:0] LEN_BYTE = 3'b000;
    localparam logic [2:0] LEN_HALF = 3'b001;
    localparam logic [2:0] LEN_WORD = 3'b011;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic SIGN_EX   = 1'b1;
    localparam logic UNSIGN_EX = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ls_state_e;

    typedef struct packed {
        logic [2:0] len;
        logic       rw;
        logic       sign;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [OPC_W-1:0] op);
        op_dec_t d;
        d.rw   = (op == OP_SB || op == OP_SH || op == OP_SW) ? WRITE : READ;
        d.sign = (op == OP_LBU || op == OP_LHU) ? UNSIGN_EX : SIGN_EX;
        case (op)
            OP_LB, OP_LBU, OP_SB: d.len = LEN_BYTE;
            OP_LH, OP_LHU, OP_SH: d.len = LEN_HALF;
            default:              d.len = LEN_WORD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ls_queue_unit_fifo.sv
// In-order circular buffer for queued memory ops. Pointers carry a wrap bit so
// full and empty are distinguishable; flush_tail rewinds the tail directly.
module ls_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush_tail,
    input  logic [PW:0]      flush_ptr,
    output logic [WIDTH-1:0] head_data,
    output logic [PW:0]      head_ptr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      head_q;
    logic [PW:0]      tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (pop)
                head_q <= head_q + (PW+1)'(1);
            if (flush_tail)
                tail_q <= flush_ptr;
            else if (push)
                tail_q <= tail_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_tail)
            mem[tail_q[PW-1:0]] <= push_data;
    end

    assign head_data = mem[head_q[PW-1:0]];
    assign head_ptr  = head_q;
    assign count     = CW'(tail_q - head_q);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (head_q == tail_q);

endmodule

// File: rtl/ls_queue_unit.sv
// Load/store queue: buffers ops in order, issues one memory access at a time,
// holds stores until committed and returns extended load data to the ROB.
//
// state | meaning
// IDLE  | no access outstanding; head may issue this cycle
// WAIT  | access issued, waiting for LSoutEn; memory fields held
module ls_queue_unit
    import ls_queue_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LSworkEn,
    input  logic [OP_W-1:0]   opCode,
    input  logic [DATA_W-1:0] operandO,
    input  logic [DATA_W-1:0] operandT,
    input  logic [DATA_W-1:0] imm,
    input  logic [TAG_W-1:0]  wrtTag,
    output logic              LSfull,
    input  logic              storeCommit,
    input  logic              flush,
    output logic              dataEn,
    output logic              LSRW,
    output logic [ADDR_W-1:0] dataAddr,
    output logic [2:0]        LSlen,
    output logic [DATA_W-1:0] Sdata,
    input  logic              LSoutEn,
    input  logic [DATA_W-1:0] Ldata,
    output logic              LSROBen,
    output logic [DATA_W-1:0] LSROBdata,
    output logic [TAG_W-1:0]  LSROBtag,
    output logic              LSdone
);

    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int OFF_TAG  = 5;
    localparam int OFF_DATA = OFF_TAG + TAG_W;
    localparam int OFF_ADDR = OFF_DATA + DATA_W;
    localparam int EW       = OFF_ADDR + ADDR_W;

    ls_state_e         state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d, commit_cred;
    logic              kill_q, kill_d;
    logic              issue, complete, store_done, rob_wr;
    logic              push;
    op_dec_t           dec;
    logic [EW-1:0]     push_data, head_data;
    logic [PW:0]       head_ptr, flush_ptr;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data, ld_ext;
    logic [TAG_W-1:0]  h_tag;
    logic [2:0]        h_len;
    logic              h_rw, h_sign;

    assign dec       = decode_op(OPC_W'(opCode));
    assign push      = LSworkEn && !fifo_full && !flush;
    assign push_data = {ADDR_W'(operandO + imm), operandT, wrtTag, dec.len, dec.rw, dec.sign};

    assign h_sign = head_data[0];
    assign h_rw   = head_data[1];
    assign h_len  = head_data[4:2];
    assign h_tag  = head_data[OFF_TAG +: TAG_W];
    assign h_data = head_data[OFF_DATA +: DATA_W];
    assign h_addr = head_data[OFF_ADDR +: ADDR_W];

    // Committed stores sit at the head; an in-flight load is the only other survivor.
    assign commit_cred = credit_q + CW'(storeCommit);
    assign flush_ptr   = (state_q == WAIT && LSRW == READ) ? head_ptr + (PW+1)'(1)
                                                           : head_ptr + (PW+1)'(commit_cred);

    ls_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (complete),
        .flush_tail (flush),
        .flush_ptr  (flush_ptr),
        .head_data  (head_data),
        .head_ptr   (head_ptr),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign LSfull = (fifo_count == CW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty && !flush && (h_rw == READ || credit_q != '0)) begin
                issue   = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (LSoutEn) begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign store_done = complete && LSRW == WRITE;
    assign rob_wr     = complete && LSRW == READ && !kill_q && !flush;

    always_comb begin
        credit_d = credit_q;
        if (storeCommit && !store_done)
            credit_d = credit_q + CW'(1);
        else if (!storeCommit && store_done)
            credit_d = credit_q - CW'(1);
    end

    always_comb begin
        kill_d = kill_q;
        if (complete)
            kill_d = 1'b0;
        else if (flush && state_q == WAIT && LSRW == READ)
            kill_d = 1'b1;
    end

    always_comb begin
        case (h_len)
            LEN_BYTE: ld_ext = {{(DATA_W-8){h_sign & Ldata[7]}}, Ldata[7:0]};
            LEN_HALF: ld_ext = {{(DATA_W-16){h_sign & Ldata[15]}}, Ldata[15:0]};
            default:  ld_ext = Ldata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q  <= '0;
            kill_q    <= 1'b0;
            dataEn    <= 1'b0;
            LSRW      <= READ;
            dataAddr  <= '0;
            LSlen     <= '0;
            Sdata     <= '0;
            LSROBen   <= 1'b0;
            LSROBdata <= '0;
            LSROBtag  <= '0;
            LSdone    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            kill_q   <= kill_d;
            dataEn   <= issue;
            LSdone   <= complete;
            LSROBen  <= rob_wr;
            if (issue) begin
                dataAddr <= h_addr;
                LSlen    <= h_len;
                LSRW     <= h_rw;
                Sdata    <= (h_rw == WRITE) ? h_data : '0;
            end
            if (rob_wr) begin
                LSROBdata <= ld_ext;
                LSROBtag  <= h_tag;
            end
        end
    end

endmodule

// File: tb/tb_ls_queue_unit.sv
// Directed bench for ls_queue_unit: a load vector table plus hand-written
// store, flush, full-queue and reset sequences.
module tb_ls_queue_unit;
    import ls_queue_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        LSworkEn, storeCommit, flush, LSoutEn;
    logic [5:0]  opCode;
    logic [31:0] operandO, operandT, imm, Ldata;
    logic [3:0]  wrtTag;
    logic        LSfull, dataEn, LSRW, LSROBen, LSdone;
    logic [31:0] dataAddr, Sdata, LSROBdata;
    logic [2:0]  LSlen;
    logic [3:0]  LSROBtag;

    int pass_cnt = 0;
    int total_cnt = 0;

    ls_queue_unit dut (
        .clk(clk), .rst(rst), .LSworkEn(LSworkEn), .opCode(opCode),
        .operandO(operandO), .operandT(operandT), .imm(imm), .wrtTag(wrtTag),
        .LSfull(LSfull), .storeCommit(storeCommit), .flush(flush),
        .dataEn(dataEn), .LSRW(LSRW), .dataAddr(dataAddr), .LSlen(LSlen),
        .Sdata(Sdata), .LSoutEn(LSoutEn), .Ldata(Ldata), .LSROBen(LSROBen),
        .LSROBdata(LSROBdata), .LSROBtag(LSROBtag), .LSdone(LSdone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] base;
        logic [31:0] off;
        logic [3:0]  tag;
        logic [31:0] ld;
        logic [31:0] exp_addr;
        logic [2:0]  exp_len;
        logic [31:0] exp_rob;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic enq(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] o, input logic [3:0] t, input logic commit);
        opCode = op; operandO = a; operandT = b; imm = o; wrtTag = t;
        LSworkEn = 1'b1; storeCommit = commit;
        tick();
        LSworkEn = 1'b0; storeCommit = 1'b0;
    endtask

    task automatic wait_en(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (dataEn) begin ok = 1'b1; break; end
            tick(); cyc++;
        end
    endtask

    task automatic no_issue(input string nm, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dataEn || LSROBen) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    task automatic complete_access(input logic [31:0] ld);
        LSoutEn = 1'b1; Ldata = ld;
        tick();
        LSoutEn = 1'b0; Ldata = '0;
    endtask

    task automatic do_load(input vec_t v);
        bit ok; int cyc;
        enq(v.op, v.base, 32'hCAFEBABE, v.off, v.tag, 1'b0);
        wait_en(ok, cyc);
        chk("load_issue", 32'(ok), 32'd1);
        chk("load_latency", 32'(cyc), 32'd1);
        chk("load_addr", dataAddr, v.exp_addr);
        chk("load_len", 32'(LSlen), 32'(v.exp_len));
        chk("load_rw", 32'(LSRW), 32'(READ));
        chk("load_sdata", Sdata, 32'd0);
        tick();
        chk("load_en_pulse", 32'(dataEn), 32'd0);
        complete_access(v.ld);
        chk("load_done", 32'(LSdone), 32'd1);
        chk("load_roben", 32'(LSROBen), 32'd1);
        chk("load_robdata", LSROBdata, v.exp_rob);
        chk("load_robtag", 32'(LSROBtag), 32'(v.tag));
        tick();
        chk("load_done_pulse", 32'({LSdone, LSROBen}), 32'd0);
    endtask

    task automatic pop_store(input string nm, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bit ok; int cyc;
        storeCommit = 1'b1;
        tick();
        storeCommit = 1'b0;
        wait_en(ok, cyc);
        chk({nm, "_issue"}, 32'(ok), 32'd1);
        chk({nm, "_addr"}, dataAddr, exp_addr);
        chk({nm, "_rw"}, 32'(LSRW), 32'(WRITE));
        chk({nm, "_sdata"}, Sdata, exp_data);
        complete_access(32'h0);
        chk({nm, "_done"}, 32'({LSdone, LSROBen}), 32'b10);
    endtask

    initial begin
        bit ok; int cyc;
        vecs[0] = '{OP_LB,  32'h100,  32'h4,        4'd5,  32'h00000080, 32'h104,  LEN_BYTE, 32'hFFFFFF80};
        vecs[1] = '{OP_LHU, 32'h2000, 32'h10,       4'd6,  32'h00008001, 32'h2010, LEN_HALF, 32'h00008001};
        vecs[2] = '{OP_LW,  32'h3000, 32'hFFFFFFFC, 4'd7,  32'hDEADBEEF, 32'h2FFC, LEN_WORD, 32'hDEADBEEF};
        vecs[3] = '{OP_LH,  32'h40,   32'h2,        4'd8,  32'h12348001, 32'h42,   LEN_HALF, 32'hFFFF8001};
        vecs[4] = '{OP_LBU, 32'h50,   32'h1,        4'd9,  32'hAAAA55F0, 32'h51,   LEN_BYTE, 32'h000000F0};
        vecs[5] = '{OP_LB,  32'h60,   32'h0,        4'd10, 32'hFFFFFF7F, 32'h60,   LEN_BYTE, 32'h0000007F};

        rst = 1'b1; LSworkEn = 0; storeCommit = 0; flush = 0; LSoutEn = 0;
        opCode = '0; operandO = '0; operandT = '0; imm = '0; wrtTag = '0; Ldata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_outputs", 32'({dataEn, LSRW, LSROBen, LSdone, LSfull}), 32'd0);
        chk("rst_fields", dataAddr | Sdata | LSROBdata | 32'(LSlen) | 32'(LSROBtag), 32'd0);

        complete_access(32'h1234);
        chk("idle_lsouten_ignored", 32'({LSdone, LSROBen}), 32'd0);

        foreach (vecs[i]) do_load(vecs[i]);

        // committed-before-flush store survives; later LW and uncommitted SB do not
        enq(OP_SW, 32'h800, 32'h11111111, 32'h0, 4'd1, 1'b1);
        enq(OP_LW, 32'h900, 32'h0, 32'h0, 4'd2, 1'b0);
        chk("fl_sw_issue", 32'(dataEn), 32'd1);
        chk("fl_sw_addr", dataAddr, 32'h800);
        chk("fl_sw_sdata", Sdata, 32'h11111111);
        enq(OP_SB, 32'hA00, 32'h22, 32'h0, 4'd3, 1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        complete_access(32'h0);
        chk("fl_sw_done", 32'({LSdone, LSROBen}), 32'b10);
        no_issue("fl_queue_empty", 6);
        chk("fl_lsfull", 32'(LSfull), 32'd0);
        do_load(vecs[1]);

        // load in flight squashed by flush
        enq(OP_LW, 32'h700, 32'h0, 32'h0, 4'd2, 1'b0);
        wait_en(ok, cyc);
        chk("kl_issue", 32'(ok), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        complete_access(32'h55555555);
        chk("kl_done_no_rob", 32'({LSdone, LSROBen}), 32'b10);
        do_load(vecs[0]);

        // storeCommit in the flush cycle keeps the store
        enq(OP_SB, 32'hB00, 32'h000000AB, 32'h0, 4'd3, 1'b0);
        no_issue("cf_wait_commit", 3);
        storeCommit = 1'b1; flush = 1'b1; tick(); storeCommit = 1'b0; flush = 1'b0;
        wait_en(ok, cyc);
        chk("cf_issue", 32'(ok), 32'd1);
        chk("cf_addr", dataAddr, 32'hB00);
        chk("cf_len", 32'(LSlen), 32'(LEN_BYTE));
        complete_access(32'h0);
        chk("cf_done", 32'({LSdone, LSROBen}), 32'b10);

        // uncommitted SW stalls, then issues on commit
        enq(OP_SW, 32'h1000, 32'h12345678, 32'h8, 4'd4, 1'b0);
        no_issue("sw_stall", 10);
        pop_store("sw", 32'h1008, 32'h12345678);
        chk("sw_len", 32'(LSlen), 32'(LEN_WORD));
        enq(OP_SW, 32'h1100, 32'h9, 32'h0, 4'd4, 1'b0);
        no_issue("sw_credit_zero", 5);
        flush = 1'b1; tick(); flush = 1'b0;

        // fill to DEPTH, reject the 5th, pop one, accept one
        for (int i = 0; i < 4; i++) begin
            enq(OP_SW, 32'hC00 + 32'(i * 4), 32'(i + 1), 32'h0, 4'(i), 1'b0);
            chk("fill_lsfull", 32'(LSfull), (i == 3) ? 32'd1 : 32'd0);
        end
        enq(OP_SW, 32'hD00, 32'hDD, 32'h0, 4'd9, 1'b0);
        chk("fill_5th_blocked", 32'(LSfull), 32'd1);
        pop_store("fill0", 32'hC00, 32'd1);
        chk("fill_after_pop", 32'(LSfull), 32'd0);
        enq(OP_SW, 32'hE00, 32'hEE, 32'h0, 4'd10, 1'b0);
        chk("fill_refull", 32'(LSfull), 32'd1);
        pop_store("fill1", 32'hC04, 32'd2);
        pop_store("fill2", 32'hC08, 32'd3);
        pop_store("fill3", 32'hC0C, 32'd4);
        pop_store("fill4", 32'hE00, 32'hEE);
        chk("fill_drained", 32'(LSfull), 32'd0);

        // reset during an access abandons it
        enq(OP_LW, 32'h1200, 32'h0, 32'h0, 4'd6, 1'b0);
        wait_en(ok, cyc);
        chk("rs_issue", 32'(ok), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        complete_access(32'h77777777);
        chk("rs_no_result", 32'({dataEn, LSdone, LSROBen}), 32'd0);
        no_issue("rs_queue_empty", 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ls_queue_unit.md
# ls_queue_unit

Parametrised load/store unit between the LS buffer and the data-memory port. It accepts up to DEPTH load/store operations into an in-order queue and issues them to memory one at a time. Loads return sign/zero-extended results to the ROB by tag. Stores issue only after the ROB has committed them, and a flush discards all speculative entries while keeping committed stores.

## Interface
- DATA_W, 32, operand/data width
- ADDR_W, 32, memory address width
- TAG_W, 4, ROB tag width
- OP_W, 6, opcode width
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- LSworkEn  in  1  new op valid
- opCode  in  OP_W  LB/LH/LW/LBU/LHU/SB/SH/SW
- operandO, operandT, imm  in  DATA_W  base, store data, offset
- wrtTag  in  TAG_W  ROB destination tag
- LSfull  out  1  combinational: count == DEPTH
- storeCommit  in  1  ROB commits the oldest uncommitted store this cycle
- flush  in  1  misprediction squash
- dataEn  out  1  one-cycle memory request strobe
- LSRW  out  1  Read=0 / Write=1
- dataAddr  out  ADDR_W; LSlen out 3; Sdata out DATA_W
- LSoutEn  in  1  memory completion; Ldata in DATA_W
- LSROBen  out  1; LSROBdata out DATA_W; LSROBtag out TAG_W
- LSdone  out  1  one-cycle pulse per completed access

## Operation
- Enqueue when LSworkEn && !LSfull && !flush. Stored fields: addr = (operandO+imm)[ADDR_W-1:0], operandT, tag, len, rw, sign.
- No enqueue bypass: a full queue blocks input even if the head pops in the same cycle.
- Length codes: Byte=3'b000, Half=3'b001, Word=3'b011.
- Unsigned loads are LBU and LHU. Every other op is marked sign-extend.
- credit counter, width $clog2(DEPTH+1):
  - +1 on storeCommit.
  - −1 when a store completes.
  - Both in the same cycle: unchanged.
- FSM IDLE/WAIT:
  - IDLE → WAIT when the queue is non-empty and either the head is a load, or the head is a store and credit>0. On this transition drive dataEn=1 for one cycle with the head fields.
  - WAIT: hold dataAddr/LSlen/LSRW/Sdata. dataEn=0.
  - WAIT → IDLE on LSoutEn: pop the head and pulse LSdone.
  - If the completed access is a load and kill=0, also pulse LSROBen with the head's tag and extended data.
- Extension:
  - Byte: {24{s&Ldata[7]}, Ldata[7:0]}
  - Half: {16{s&Ldata[15]}, Ldata[15:0]}
  - Word: Ldata
- Flush:
  - tail ← head + credit. The committed stores at the head are retained.
  - Exception: in WAIT with a load in flight, tail ← head+1 and kill ← 1. The load is popped on LSoutEn with no LSROBen. kill clears on that pop.
  - In WAIT with a store in flight: the store is committed, so it is retained and completes normally.
  - A storeCommit in the same cycle as flush is counted before computing tail.
  - flush overrides LSworkEn (input dropped).
- storeCommit beyond the number of queued stores is a protocol violation and is not checked.
- When LSRW=Read, Sdata=0. For loads, Sdata is always 0.

## Timing
- Reset values: all outputs 0; LSRW=Read; LSfull=0. Queue empty, credit=0, kill=0, state IDLE.
- An op enqueued at edge k asserts dataEn after edge k+1 (earliest).
- LSoutEn sampled high at edge m produces LSROBen/LSdone high during cycle m→m+1, for exactly one cycle.
- Back-to-back issue: the next dataEn follows no earlier than one cycle after the LSdone cycle.
- LSoutEn is ignored in IDLE.
- rst mid-access abandons the access. No result is produced.

## Structure
- Shared package/defines, extending defines.v:
  - opcode constants
  - Byte/Half/Word length codes
  - Read/Write
  - SignEx/UnsignEx
  - IDLE/WAIT state encoding
- Sub-module ls_fifo: circular buffer with head/tail pointers of width $clog2(DEPTH) plus a wrap bit, push/pop, a flush_tail load port, and count/full/empty outputs.
- Extension logic and the FSM live in ls_queue_unit.

## Test plan
- LB with operandO=0x100, imm=4; Ldata=0x80 → dataAddr=0x104, LSlen=000, LSROBdata=0xFFFFFF80, tag echoed.
- LHU with Ldata=0x0000_8001 → LSROBdata=0x00008001. LW with Ldata=0xDEADBEEF → 0xDEADBEEF.
- SW with operandT=0x12345678 and no storeCommit for 10 cycles → no dataEn, no LSROBen. After storeCommit: dataEn with LSRW=1, Sdata=0x12345678. After LSoutEn: LSdone only, credit returns to 0.
- Queue SW(committed), LW, SB(uncommitted), then flush → only the SW issues and completes. The queue is then empty and LSfull=0.
- LW in flight, flush, then LSoutEn → LSdone=1, LSROBen=0. The next op enqueued issues normally.
- Fill DEPTH=4 entries → LSfull=1 and the 5th LSworkEn is not accepted. After one pop, LSfull=0 and the next op is accepted.
